// File: rtl/tecmo_pkg.sv
// Shared widths and the word-buffer entry type for the ROM download path.
package tecmo_pkg;
  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;
  localparam int IOCTL_ADDR_W = 20;
  localparam int WORD_ADDR_W  = IOCTL_ADDR_W - 2;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0]  addr;
    logic [SDRAM_DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic {WR_IDLE, WR_REQ} wr_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy and same-cycle push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/ioctl_sdram_writer.sv
// Packs the hps_io download byte stream into 32-bit SDRAM writes, buffering
// words in a small FIFO and throttling the HPS with ioctl_wait.
module ioctl_sdram_writer
  import tecmo_pkg::*;
#(
  parameter int                      FIFO_DEPTH = 4,
  parameter logic [SDRAM_ADDR_W-1:0] SDRAM_BASE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
  input  logic [7:0]               ioctl_data,
  input  logic                     ioctl_wr,
  input  logic                     ioctl_download,
  output logic                     ioctl_wait,
  output logic [SDRAM_ADDR_W-1:0]  sdram_addr,
  output logic [SDRAM_DATA_W-1:0]  sdram_data,
  output logic                     sdram_we,
  output logic                     sdram_req,
  input  logic                     sdram_ack,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_ADDR_W-1:0]   word_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_ADDR_W-1:0]  wa, in_wa;
  logic [SDRAM_DATA_W-1:0] dreg, nd;
  logic [3:0]              mask, nm;
  logic [1:0]              lane, nc;
  logic                    skid_valid, skid_nxt_valid;
  wr_entry_t               skid, skid_nxt;
  wr_entry_t               cand [3];
  logic                    dl_q, dl_fall, dl_rise, flush_old, busy_q;
  wr_state_t               state;

  wr_entry_t               fifo_din, fifo_dout;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count, count_nxt;

  sync_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign lane    = ioctl_addr[1:0];
  assign in_wa   = ioctl_addr[IOCTL_ADDR_W-1:2];
  assign dl_fall = dl_q & ~ioctl_download;
  assign dl_rise = ~dl_q & ioctl_download;

  // Up to three words can be ready in one cycle (skid, flushed partial, completed
  // word); the oldest goes to the FIFO and at most one remains in the skid.
  always_comb begin
    flush_old = ioctl_wr && (mask != '0) && (in_wa != wa);
    nd        = flush_old ? '0 : dreg;
    nd[{lane, 3'b000} +: 8] = ioctl_data;
    nm        = (flush_old ? 4'b0000 : mask) | (4'b0001 << lane);
    nc        = '0;
    cand[0]   = '0;
    cand[1]   = '0;
    cand[2]   = '0;
    if (skid_valid) begin
      cand[0] = skid;
      nc      = 2'd1;
    end
    if (flush_old || (dl_fall && !ioctl_wr && (mask != '0))) begin
      cand[nc] = '{addr: wa, data: dreg};
      nc       = nc + 2'd1;
    end
    if (ioctl_wr && lane == 2'd3) begin
      cand[nc] = '{addr: in_wa, data: nd};
      nc       = nc + 2'd1;
    end
    fifo_pop       = (state == WR_REQ) & sdram_ack;
    fifo_push      = (nc != '0) & (~fifo_full | fifo_pop);
    fifo_din       = cand[0];
    skid_nxt_valid = fifo_push ? (nc >= 2'd2) : (nc >= 2'd1);
    skid_nxt       = fifo_push ? cand[1] : cand[0];
    count_nxt      = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  end

  assign busy = dl_q | (mask != '0) | skid_valid | ~fifo_empty | (state != WR_IDLE);
  assign done = busy_q & ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wa         <= '0;
      dreg       <= '0;
      mask       <= '0;
      skid_valid <= 1'b0;
      skid       <= '0;
      dl_q       <= 1'b0;
      busy_q     <= 1'b0;
      ioctl_wait <= 1'b0;
      state      <= WR_IDLE;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      word_count <= '0;
    end else begin
      dl_q       <= ioctl_download;
      busy_q     <= busy;
      skid_valid <= skid_nxt_valid;
      skid       <= skid_nxt;
      ioctl_wait <= (count_nxt >= CW'(FIFO_DEPTH - 2)) | skid_nxt_valid;

      if (ioctl_wr) begin
        wa <= in_wa;
        if (lane == 2'd3) begin
          mask <= '0;
          dreg <= '0;
        end else begin
          mask <= nm;
          dreg <= nd;
        end
      end else if (dl_fall) begin
        mask <= '0;
        dreg <= '0;
      end

      case (state)
        WR_IDLE: if (!fifo_empty) begin
          sdram_addr <= SDRAM_BASE + {{(SDRAM_ADDR_W-WORD_ADDR_W){1'b0}}, fifo_dout.addr};
          sdram_data <= fifo_dout.data;
          sdram_req  <= 1'b1;
          sdram_we   <= 1'b1;
          state      <= WR_REQ;
        end
        WR_REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          sdram_we  <= 1'b0;
          state     <= WR_IDLE;
        end
        default: state <= WR_IDLE;
      endcase

      if (dl_rise)       word_count <= '0;
      else if (fifo_pop) word_count <= word_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// Randomized download sessions scored against a byte-grouping reference model.
module tb_ioctl_sdram_writer;
  localparam logic [22:0] BASE = 23'h10000;

  logic        clk = 1'b0, reset = 1'b1;
  logic [19:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0, ioctl_download = 1'b0, ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req, sdram_ack = 1'b0, busy, done;
  logic [17:0] word_count;

  always #5 clk = ~clk;

  ioctl_sdram_writer #(.FIFO_DEPTH(4), .SDRAM_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .busy(busy), .done(done),
    .word_count(word_count)
  );

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: group bytes by word address, emit on lane 3, address change or end.
  logic [54:0] exp_q [$];
  logic [7:0]  m_bytes [4];
  logic [17:0] m_wa = '0;
  logic [3:0]  m_mask = '0;
  int          m_words = 0;

  task automatic m_emit();
    logic [22:0] a;
    a = BASE + {5'b0, m_wa};
    exp_q.push_back({a, m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    m_mask = '0;
    m_words++;
  endtask

  task automatic m_byte(input logic [19:0] a, input logic [7:0] d);
    if (m_mask != 0 && a[19:2] != m_wa) m_emit();
    m_wa = a[19:2];
    m_bytes[a[1:0]] = d;
    m_mask[a[1:0]] = 1'b1;
    if (a[1:0] == 2'd3) m_emit();
  endtask

  task automatic m_clear();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    m_mask = '0;
  endtask

  // HPS sees ioctl_wait one cycle late, so one extra write can follow its rise.
  logic wait_cur = 1'b0, wait_stale = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    wait_stale = wait_cur;
    wait_cur   = ioctl_wait;
  end

  // SDRAM controller stand-in and write scoreboard.
  int          ack_dly = 2, wcnt = 0, done_cnt = 0;
  logic        hold = 1'b0;
  logic [22:0] last_addr = '0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (sdram_ack) sdram_ack = 1'b0;
    else if (sdram_req && !hold && !reset) begin
      if (wcnt >= ack_dly) begin
        sdram_ack = 1'b1;
        wcnt = 0;
        last_addr = sdram_addr;
        check("we_with_req", sdram_we, 1'b1);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("write_word", {sdram_addr, sdram_data}, exp_q.pop_front());
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic send(input logic [19:0] a, input logic [7:0] d);
    int g = 0;
    while (wait_stale && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("send_wait_bound", g < 1000, 1'b1);
    if (g >= 1000) return;
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    m_byte(a, d);
  endtask

  int done0;
  task automatic begin_dl();
    ioctl_download = 1'b1;
    m_words = 0;
    done0 = done_cnt;
    @(negedge clk);
  endtask

  task automatic end_dl(input string tag);
    int g = 0;
    ioctl_download = 1'b0;
    if (m_mask != 0) m_emit();
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 3000);
    check({tag, "_idle"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    check({tag, "_wcount"}, word_count, 18'(m_words));
    check({tag, "_done"}, done_cnt - done0, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic scen1(input string tag);
    begin_dl();
    for (int i = 0; i < 8; i++) send(20'(i), 8'(i));
    end_dl(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req", sdram_req, 0);
    check("rst_we", sdram_we, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wcount", word_count, 0);
    check("rst_addr_data", {sdram_addr, sdram_data}, 0);

    ack_dly = 2;
    scen1("s1");

    begin_dl();
    for (int i = 0; i < 5; i++) send(20'(i), 8'(i));
    end_dl("s2");

    begin_dl();
    for (int i = 0; i < 4; i++) send(20'h00100 + 20'(i), 8'($urandom));
    end_dl("s3");
    check("s3_addr", last_addr, 23'h10040);

    // Stall the controller with a continuous stream behind it.
    ack_dly = 0;
    hold = 1'b1;
    begin_dl();
    fork
      for (int i = 0; i < 40; i++) send(20'h00200 + 20'(i), 8'($urandom));
      begin
        repeat (200) @(negedge clk);
        check("s4_wait_high", ioctl_wait, 1'b1);
        check("s4_req_held", sdram_req, 1'b1);
        hold = 1'b0;
      end
    join
    end_dl("s4");

    begin_dl();
    send(20'h0, 8'hAA);
    send(20'h1, 8'hBB);
    send(20'h8, 8'hCC);
    end_dl("s5");

    for (int s = 0; s < 5; s++) begin
      logic [19:0] a;
      int n;
      ack_dly = $urandom_range(0, 4);
      n = $urandom_range(20, 60);
      a = 20'($urandom);
      begin_dl();
      for (int i = 0; i < n; i++) begin
        int r;
        send(a, 8'($urandom));
        r = $urandom_range(0, 15);
        if (r == 0)      a = 20'($urandom);
        else if (r == 1) a = a + 20'd2;
        else             a = a + 20'd1;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      end_dl($sformatf("rnd%0d", s));
    end

    // Reset in the middle of a pending request; queued words are discarded.
    hold = 1'b1;
    begin_dl();
    for (int i = 0; i < 6; i++) send(20'(i), 8'(i + 16));
    begin
      int g = 0;
      while (!sdram_req && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("s6_req_seen", sdram_req, 1'b1);
    end
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("s6_req", sdram_req, 0);
    check("s6_busy", busy, 0);
    check("s6_wcount", word_count, 0);
    check("s6_wait", ioctl_wait, 0);
    m_clear();
    hold = 1'b0;
    ack_dly = 2;
    @(negedge clk);
    scen1("s6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
